// File: rtl/systolic_drain_bf16_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_drain_bf16_if
// Purpose  : Bundles the south-edge result stream of the bf16 systolic array
//            drain. It carries the skewed fp32 input side, the bf16 row output
//            stream and the overflow status/clear.
// Ports    : i_valid    column-0 result valid (column-0 timing)
//            i_south    COLS x fp32 psums, lane c = [32c+31:32c]
//            o_valid    FIFO head row available
//            i_ready    consumer accepts head row
//            o_row      COLS x bf16 head row, lane c = [16c+15:16c]
//            o_count    rows held in the FIFO
//            o_overflow sticky row-dropped flag
//            i_clr_ovf  synchronous clear of o_overflow
//            Modport slave is the drain block; modport master is its
//            environment (array edge plus writeback consumer).
// Revision : 1.0  initial release
// ============================================================================
interface systolic_drain_bf16_if #(
   parameter int COLS  = 4,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                 i_valid;
   logic [COLS*32-1:0]   i_south;
   logic                 o_valid;
   logic                 i_ready;
   logic [COLS*16-1:0]   o_row;
   logic [CW-1:0]        o_count;
   logic                 o_overflow;
   logic                 i_clr_ovf;

   modport master (
      output i_valid, i_south, i_ready, i_clr_ovf,
      input  o_valid, o_row, o_count, o_overflow
   );

   modport slave (
      input  i_valid, i_south, i_ready, i_clr_ovf,
      output o_valid, o_row, o_count, o_overflow
   );
endinterface
`default_nettype wire

// File: rtl/systolic_drain_bf16.sv
`default_nettype none
// ============================================================================
// Module   : systolic_drain_bf16
// Purpose  : South-edge result collector for the weight-stationary bf16
//            systolic array. Re-aligns the skewed fp32 partial sums, rounds
//            each lane to bf16 (round-to-nearest-even, quiet NaN), and buffers
//            whole rows in a FIFO drained over a valid/ready stream. The array
//            cannot stall, so a row arriving at a full FIFO is dropped and a
//            sticky overflow flag is raised.
// Ports    : clk    rising-edge clock
//            reset  asynchronous, active-low reset
//            bus    systolic_drain_bf16_if.slave (stream in/out, status)
// Params   : COLS   result lanes (>=1)
//            DEPTH  FIFO depth in rows (power of two, >=2)
// Latency  : i_valid in cycle t0 -> o_valid in cycle t0+COLS+1 (empty FIFO)
// Revision : 1.0  initial release
// ============================================================================
module systolic_drain_bf16 #(
   parameter int COLS  = 4,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   systolic_drain_bf16_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = COLS * 16;
   localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

   // -------------------------------------------------------------------------
   // fp32 -> bf16, round to nearest even. NaNs are replaced by a canonical
   // quiet NaN keeping the sign; everything else (Inf, zero, subnormals) goes
   // through the plain rounding add, whose carry may legitimately ripple into
   // the exponent (max finite -> Inf).
   // -------------------------------------------------------------------------
   function automatic logic [15:0] f_rne(input logic [31:0] x);
      logic w_nan;
      logic w_inc;
      w_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      w_inc = x[15] & (x[16] | (|x[14:0]));
      if (w_nan) begin
         f_rne = {x[31], 8'hFF, 7'h40};
      end else begin
         f_rne = x[31:16] + {15'd0, w_inc};
      end
   endfunction

   // -------------------------------------------------------------------------
   // Deskew: the valid travels with column 0, so it needs the longest delay
   // (COLS-1); lane c arrives c cycles late and is delayed COLS-1-c cycles.
   // -------------------------------------------------------------------------
   logic             w_aln_valid;
   logic [COLS*32-1:0] w_aln_data;

   if (COLS > 1) begin : g_vdly
      logic [COLS-2:0] r_vsr;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_vsr <= '0;
         end else begin
            r_vsr[0] <= bus.i_valid;
            for (int k = 1; k < COLS - 1; k++) begin
               r_vsr[k] <= r_vsr[k-1];
            end
         end
      end
      assign w_aln_valid = r_vsr[COLS-2];
   end else begin : g_vnodly
      assign w_aln_valid = bus.i_valid;
   end

   for (genvar c = 0; c < COLS; c++) begin : g_lane
      localparam int D = COLS - 1 - c;
      if (D > 0) begin : g_dly
         logic [31:0] r_sr [D];
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int k = 0; k < D; k++) begin
                  r_sr[k] <= '0;
               end
            end else begin
               r_sr[0] <= bus.i_south[32*c +: 32];
               for (int k = 1; k < D; k++) begin
                  r_sr[k] <= r_sr[k-1];
               end
            end
         end
         assign w_aln_data[32*c +: 32] = r_sr[D-1];
      end else begin : g_nodly
         // Last lane arrives exactly at alignment time.
         assign w_aln_data[32*c +: 32] = bus.i_south[32*c +: 32];
      end
   end

   // -------------------------------------------------------------------------
   // Round stage: one register after alignment.
   // -------------------------------------------------------------------------
   logic [RW-1:0] w_rnd_row;
   logic          r_rnd_valid;
   logic [RW-1:0] r_rnd_row;

   for (genvar c = 0; c < COLS; c++) begin : g_rnd
      assign w_rnd_row[16*c +: 16] = f_rne(w_aln_data[32*c +: 32]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rnd_valid <= 1'b0;
         r_rnd_row   <= '0;
      end else begin
         r_rnd_valid <= w_aln_valid;
         r_rnd_row   <= w_rnd_row;
      end
   end

   // -------------------------------------------------------------------------
   // Row FIFO. o_valid comes only from the registered count, so there is no
   // combinational path from i_ready to o_valid. A pop in the same cycle frees
   // the slot for a push into a full FIFO.
   // -------------------------------------------------------------------------
   logic [RW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;

   logic w_nempty;
   logic w_full;
   logic w_pop;
   logic w_push_ok;
   logic w_drop;

   assign w_nempty  = (r_count != '0);
   assign w_full    = (r_count == c_DEPTH);
   assign w_pop     = w_nempty & bus.i_ready;
   assign w_push_ok = r_rnd_valid & (~w_full | w_pop);
   assign w_drop    = r_rnd_valid & w_full & ~w_pop;

   // Storage holds no reset: the read side masks it while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= r_rnd_row;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow; a new drop wins over a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (bus.i_clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign bus.o_valid    = w_nempty;
   assign bus.o_row      = w_nempty ? r_mem[r_rptr] : '0;
   assign bus.o_count    = r_count;
   assign bus.o_overflow = r_ovf;

endmodule
`default_nettype wire
